fetch_unit: RTL

//  Instruction fetch front-end. Generates the word address (addra) for the 64x32

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_buffer.sv | 70 +++++++
 rtl/fetch_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front-end.
// State encoding, widths and the buffered {pc, instr} entry.
package fetch_pkg;

  localparam int PC_W    = 6;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_ent_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {pc, instr} words.
// Head always sits in slot 0; a pop shifts slot 1 down.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_i,
  input  logic       push_i,
  input  fetch_ent_t push_ent_i,
  input  logic       pop_i,
  output fetch_ent_t head_o,
  output logic       valid_o,
  output logic [1:0] occ_o
);

  fetch_ent_t ent0_q, ent0_d;
  fetch_ent_t ent1_q, ent1_d;
  logic [1:0] occ_q, occ_d;
  logic       do_pop;

  assign do_pop  = pop_i && (occ_q != 2'd0);
  assign head_o  = ent0_q;
  assign valid_o = (occ_q != 2'd0);
  assign occ_o   = occ_q;

  // Next-state: flush wins, then pop/push combinations.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    if (flush_i) begin
      occ_d = 2'd0;
    end else if (do_pop && push_i) begin
      if (occ_q == 2'd1) begin
        ent0_d = push_ent_i;
      end else begin
        ent0_d = ent1_q;
        ent1_d = push_ent_i;
      end
    end else if (do_pop) begin
      ent0_d = ent1_q;
      occ_d  = occ_q - 2'd1;
    end else if (push_i) begin
      if (occ_q == 2'd0) ent0_d = push_ent_i;
      else               ent1_d = push_ent_i;
      occ_d = occ_q + 2'd1;
    end
  end

  // Entry and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  // Issue throttling must never let a capture hit a full buffer.
  always_ff @(posedge clk) begin
    if (rst_n && push_i && !do_pop && !flush_i)
      assert (occ_q != 2'd2);
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: PC, ROM issue, capture and
// redirect/halt control feeding a 2-entry decode buffer.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              ROM_DEPTH = 12,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  output logic [PC_W-1:0]    addra,
  input  logic [INSTR_W-1:0] rom_data_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    instr_pc_o,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic               halted_o
);

  localparam logic [PC_W:0] RomEnd = (PC_W+1)'(ROM_DEPTH);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            infl_q, infl_d;
  logic [PC_W-1:0] infl_pc_q, infl_pc_d;

  logic       push, pop, flush;
  logic [1:0] occ;
  logic [2:0] need;
  logic       in_rom, redir_in_rom;
  fetch_ent_t head, cap;

  assign in_rom       = ({1'b0, pc_q} < RomEnd);
  assign redir_in_rom = ({1'b0, redirect_pc_i} < RomEnd);
  assign pop   = instr_valid_o && instr_ready_i && !redirect_i;
  assign push  = infl_q && !redirect_i;
  assign need  = {1'b0, occ} + {2'b0, infl_q} - {2'b0, pop};
  assign cap   = '{pc: infl_pc_q, instr: rom_data_i};

  assign addra      = pc_q;
  assign instr_o    = head.instr;
  assign instr_pc_o = head.pc;
  assign halted_o   = (state_q == ST_HALT) &&
                      (occ == 2'd0) && !infl_q;

  // FSM, PC advance and issue decision.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    infl_d    = 1'b0;
    infl_pc_d = infl_pc_q;
    flush     = 1'b0;
    priority case (1'b1)
      (state_q == ST_IDLE): begin
        if (start_i) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
        end
      end
      redirect_i: begin
        flush   = 1'b1;
        pc_d    = redirect_pc_i;
        state_d = redir_in_rom ? ST_RUN : ST_HALT;
      end
      (state_q == ST_RUN): begin
        if (!in_rom) begin
          state_d = ST_HALT;
        end else if (need < 3'd2) begin
          infl_d    = 1'b1;
          infl_pc_d = pc_q;
          pc_d      = pc_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      infl_q    <= infl_d;
      infl_pc_q <= infl_pc_d;
    end
  end

  fetch_buffer u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .push_i     (push),
    .push_ent_i (cap),
    .pop_i      (pop),
    .head_o     (head),
    .valid_o    (instr_valid_o),
    .occ_o      (occ)
  );

endmodule
